// File: rtl/prover_feeder_pkg.sv
// ============================================================================
// Module   : prover_feeder_pkg
// Brief    : Shared types and helpers for the adder-tree input feeder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

// Field element width normally arrives from field_arith_defs.v.
`ifndef F_NBITS
`define F_NBITS 64
`endif

package prover_feeder_pkg;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prover_feeder_bank.sv
// ============================================================================
// Module   : prover_feeder_bank
// Brief    : One vector buffer of the feeder: element storage, tag and state.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prover_feeder_bank
    import prover_feeder_pkg::*;
#(
    parameter int NGATES = 8,
    parameter int NTAGB  = 8,
    parameter int IDXW   = idx_width(NGATES)
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                we,
    input  logic [IDXW-1:0]     idx,
    input  logic [`F_NBITS-1:0] data,
    input  logic [NTAGB-1:0]    tag,
    input  logic                complete,
    input  logic                zero_fill,
    input  logic                free,
    output bank_state_t         state,
    output logic [`F_NBITS-1:0] vec [NGATES-1:0],
    output logic [NTAGB-1:0]    vec_tag
);

    bank_state_t         r_state;
    logic [`F_NBITS-1:0] r_vec [NGATES-1:0];
    logic [NTAGB-1:0]    r_tag;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= BANK_EMPTY;
            r_tag   <= '0;
            for (int j = 0; j < NGATES; j++) begin
                r_vec[j] <= '0;
            end
        end else if (free) begin
            r_state <= BANK_EMPTY;
        end else if (we) begin
            // Slots above a short vector's last element hold the additive identity.
            for (int j = 0; j < NGATES; j++) begin
                if (IDXW'(j) == idx) begin
                    r_vec[j] <= data;
                end else if (zero_fill && (IDXW'(j) > idx)) begin
                    r_vec[j] <= '0;
                end
            end
            if (idx == '0) begin
                r_tag <= tag;
            end
            r_state <= complete ? BANK_FULL : BANK_FILLING;
        end
    end

    assign state   = r_state;
    assign vec     = r_vec;
    assign vec_tag = r_tag;

endmodule

`default_nettype wire

// File: rtl/prover_adder_tree_feeder.sv
// ============================================================================
// Module   : prover_adder_tree_feeder
// Brief    : Packs serial field elements into double-buffered vectors and
//            issues them to the pipelined adder tree one strobe at a time.
// Options  : ADDER_FEEDER_PARTIAL_EN - in_last closes a vector early.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prover_adder_tree_feeder
    import prover_feeder_pkg::*;
#(
    parameter int NGATES = 8,
    parameter int NTAGB  = 8
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                in_valid,
    input  logic [`F_NBITS-1:0] in_data,
    input  logic [NTAGB-1:0]    in_tag,
    input  logic                in_last,
    output logic                in_ready,
    input  logic                tree_in_ready,
    input  logic                tree_in_ready_pulse,
    output logic                tree_en,
    output logic [`F_NBITS-1:0] tree_in [NGATES-1:0],
    output logic [NTAGB-1:0]    tree_tag,
    output logic                idle
);

    localparam int              IDXW       = idx_width(NGATES);
    localparam logic [IDXW-1:0] C_LAST_IDX = IDXW'(NGATES - 1);

    logic                r_fill_sel;
    logic                r_issue_sel;
    logic                r_holdoff;
    logic                r_tree_en;
    logic [IDXW-1:0]     r_elem_idx;

    bank_state_t         w_state0;
    bank_state_t         w_state1;
    logic [`F_NBITS-1:0] w_vec0 [NGATES-1:0];
    logic [`F_NBITS-1:0] w_vec1 [NGATES-1:0];
    logic [NTAGB-1:0]    w_tag0;
    logic [NTAGB-1:0]    w_tag1;

    bank_state_t         w_fill_state;
    bank_state_t         w_issue_state;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_short_last;
    logic                w_complete;
    logic                w_issue;

`ifdef ADDER_FEEDER_PARTIAL_EN
    assign w_short_last = in_last;
`else
    // Full-vector build: in_last has no effect.
    assign w_short_last = in_last & 1'b0;
`endif

    assign w_fill_state  = r_fill_sel  ? w_state1 : w_state0;
    assign w_issue_state = r_issue_sel ? w_state1 : w_state0;
    assign w_in_ready    = (w_fill_state != BANK_FULL);
    assign w_accept      = in_valid && w_in_ready;
    assign w_complete    = (r_elem_idx == C_LAST_IDX) || w_short_last;

    // Back-to-back strobes are suppressed so the tree sees each en once.
    assign w_issue = (w_issue_state == BANK_FULL) && tree_in_ready &&
                     !r_holdoff && !r_tree_en;

    prover_feeder_bank #(
        .NGATES (NGATES),
        .NTAGB  (NTAGB),
        .IDXW   (IDXW)
    ) u_bank0 (
        .clk       (clk),
        .rstb      (rstb),
        .we        (w_accept && !r_fill_sel),
        .idx       (r_elem_idx),
        .data      (in_data),
        .tag       (in_tag),
        .complete  (w_complete),
        .zero_fill (w_short_last),
        .free      (r_tree_en && !r_issue_sel),
        .state     (w_state0),
        .vec       (w_vec0),
        .vec_tag   (w_tag0)
    );

    prover_feeder_bank #(
        .NGATES (NGATES),
        .NTAGB  (NTAGB),
        .IDXW   (IDXW)
    ) u_bank1 (
        .clk       (clk),
        .rstb      (rstb),
        .we        (w_accept && r_fill_sel),
        .idx       (r_elem_idx),
        .data      (in_data),
        .tag       (in_tag),
        .complete  (w_complete),
        .zero_fill (w_short_last),
        .free      (r_tree_en && r_issue_sel),
        .state     (w_state1),
        .vec       (w_vec1),
        .vec_tag   (w_tag1)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_fill_sel  <= 1'b0;
            r_issue_sel <= 1'b0;
            r_elem_idx  <= '0;
            r_holdoff   <= 1'b0;
            r_tree_en   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_complete) begin
                    r_elem_idx <= '0;
                    r_fill_sel <= ~r_fill_sel;
                end else begin
                    r_elem_idx <= r_elem_idx + IDXW'(1);
                end
            end
            r_tree_en <= w_issue;
            if (r_tree_en) begin
                r_issue_sel <= ~r_issue_sel;
            end
            // Held until the tree signals it has re-armed its input level.
            if (r_tree_en) begin
                r_holdoff <= 1'b1;
            end else if (tree_in_ready_pulse) begin
                r_holdoff <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NGATES; i++) begin
            tree_in[i] = r_issue_sel ? w_vec1[i] : w_vec0[i];
        end
    end

    assign tree_tag = r_issue_sel ? w_tag1 : w_tag0;
    assign tree_en  = r_tree_en;
    assign in_ready = w_in_ready;
    assign idle     = (w_state0 == BANK_EMPTY) && (w_state1 == BANK_EMPTY) &&
                      !r_holdoff;

endmodule

`default_nettype wire

// File: tb/tb_prover_adder_tree_feeder.sv
// ============================================================================
// Module   : tb_prover_adder_tree_feeder
// Brief    : Self-checking bench for prover_adder_tree_feeder (ngates=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef F_NBITS
`define F_NBITS 64
`endif

module tb_prover_adder_tree_feeder;

    localparam int NG = 8;
    localparam int NT = 8;
    localparam int FW = `F_NBITS;

    typedef struct packed {
        logic [NT-1:0]          tag;
        logic [NG-1:0][FW-1:0]  elems;
        logic [FW-1:0]          sum;
    } exp_t;

    typedef struct packed {
        logic [NT-1:0] tag;
        logic [FW-1:0] base;
        logic [FW-1:0] sum;
        logic          chk_lat;
    } vec_case_t;

    logic          clk = 1'b0;
    logic          rstb;
    logic          in_valid;
    logic [FW-1:0] in_data;
    logic [NT-1:0] in_tag;
    logic          in_last;
    logic          in_ready;
    logic          tree_in_ready;
    logic          tree_in_ready_pulse;
    logic          tree_en;
    logic [FW-1:0] tree_in [NG-1:0];
    logic [NT-1:0] tree_tag;
    logic          idle;

    logic tb_busy, tb_hold, tb_nopulse, tb_force;
    logic armed;
    int   checks, errors, issues, blocked;
    exp_t sb_q[$];
    vec_case_t cases [4];

    prover_adder_tree_feeder #(.NGATES(NG), .NTAGB(NT)) dut (
        .clk                 (clk),
        .rstb                (rstb),
        .in_valid            (in_valid),
        .in_data             (in_data),
        .in_tag              (in_tag),
        .in_last             (in_last),
        .in_ready            (in_ready),
        .tree_in_ready       (tree_in_ready),
        .tree_in_ready_pulse (tree_in_ready_pulse),
        .tree_en             (tree_en),
        .tree_in             (tree_in),
        .tree_tag            (tree_tag),
        .idle                (idle)
    );

    always #5 clk = ~clk;

    assign tree_in_ready = !tb_busy && !tb_hold;

    task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Tree model: drops ready for a while after each en, then pulses re-arm.
    initial begin
        tb_busy = 1'b0;
        tree_in_ready_pulse = 1'b0;
        forever begin
            @(negedge clk);
            if (tb_force) begin
                tree_in_ready_pulse = 1'b1;
                @(negedge clk);
                tree_in_ready_pulse = 1'b0;
                tb_force = 1'b0;
            end else if (tree_en && !tb_nopulse) begin
                tb_busy = 1'b1;
                repeat (20) @(negedge clk);
                tb_busy = 1'b0;
                tree_in_ready_pulse = 1'b1;
                @(negedge clk);
                tree_in_ready_pulse = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (tree_in_ready_pulse) armed = 1'b1;
    end

    // Scoreboard: every issued vector must match the oldest expected one.
    always @(negedge clk) begin
        if (rstb === 1'b1 && tree_en === 1'b1) begin
            exp_t          e;
            logic [FW-1:0] s;
            issues++;
            check("issue_after_rearm", FW'(armed), FW'(1));
            armed = 1'b0;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue actual=tree_en required=none tag=%0h", tree_tag);
            end else begin
                e = sb_q.pop_front();
                s = '0;
                check("issue_tag", FW'(tree_tag), FW'(e.tag));
                for (int i = 0; i < NG; i++) begin
                    check("issue_elem", tree_in[i], e.elems[i]);
                    s = s + tree_in[i];
                end
                check("tree_sum", s, e.sum);
            end
        end
    end

    task automatic send_elem(input logic [FW-1:0] d, input logic [NT-1:0] t, input logic l);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        in_last  = l;
        while (!in_ready && guard < 400) begin
            blocked++;
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=in_ready_low required=accept data=%0h", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_vec(input logic [NT-1:0] t, input logic [FW-1:0] base, input logic [FW-1:0] sum);
        exp_t e;
        e.tag = t;
        e.sum = sum;
        for (int i = 0; i < NG; i++) e.elems[i] = base + FW'(i);
        sb_q.push_back(e);
        // Later elements carry a different tag; only the first may be latched.
        for (int i = 0; i < NG; i++) begin
            send_elem(base + FW'(i), (i == 0) ? t : ~t, 1'b0);
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (!(sb_q.size() == 0 && armed && !tb_busy && !tree_en) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("drain_done", FW'(sb_q.size() == 0 && armed), FW'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int i0;
        int n_pre;
        exp_t e;
        cases[0] = '{tag: 8'h5A, base: FW'(1),  sum: FW'(36),  chk_lat: 1'b1};
        cases[1] = '{tag: 8'h01, base: FW'(1),  sum: FW'(36),  chk_lat: 1'b0};
        cases[2] = '{tag: 8'h02, base: FW'(9),  sum: FW'(100), chk_lat: 1'b0};
        cases[3] = '{tag: 8'h03, base: FW'(17), sum: FW'(164), chk_lat: 1'b0};

        checks = 0; errors = 0; issues = 0; blocked = 0;
        armed = 1'b1; tb_hold = 1'b0; tb_nopulse = 1'b0; tb_force = 1'b0;
        rstb = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; in_last = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", FW'(in_ready), FW'(1));
        check("rst_idle", FW'(idle), FW'(1));
        check("rst_tree_en", FW'(tree_en), FW'(0));
        check("rst_tree_tag", FW'(tree_tag), FW'(0));
        check("rst_tree_in0", tree_in[0], FW'(0));
        check("rst_tree_in7", tree_in[NG-1], FW'(0));
        @(negedge clk);
        rstb = 1'b1;

        // Single vector (with latency), then three streamed vectors.
        for (int k = 0; k < 4; k++) begin
            i0 = issues;
            send_vec(cases[k].tag, cases[k].base, cases[k].sum);
            if (cases[k].chk_lat) begin
                check("lat_not_yet", FW'(tree_en), FW'(0));
                @(posedge clk);
                #1;
                check("lat_issue", FW'(tree_en), FW'(1));
                drain();
                check("single_issue_count", FW'(issues - i0), FW'(1));
            end
        end
        @(negedge clk);
        check("stream_both_full_in_ready", FW'(in_ready), FW'(0));
        check("stream_not_idle", FW'(idle), FW'(0));
        drain();

        // Backpressure: tree not ready while two vectors and one more element arrive.
        tb_hold = 1'b1;
        i0 = issues;
        blocked = 0;
        send_vec(8'h11, FW'(1), FW'(36));
        send_vec(8'h12, FW'(9), FW'(100));
        @(negedge clk);
        check("bp_in_ready_low", FW'(in_ready), FW'(0));
        fork
            send_vec(8'h13, FW'(17), FW'(164));
            begin
                repeat (6) @(negedge clk);
                check("bp_no_issue_held", FW'(issues - i0), FW'(0));
                check("bp_still_blocked", FW'(in_ready), FW'(0));
                tb_hold = 1'b0;
            end
        join
        check("bp_17th_waited", FW'(blocked > 0), FW'(1));
        drain();
        check("bp_issue_count", FW'(issues - i0), FW'(3));

        // Short vector closed by in_last.
        i0 = issues;
`ifdef ADDER_FEEDER_PARTIAL_EN
        e = '0;
        e.tag = 8'hC3;
        e.elems[0] = FW'(7);
        e.elems[1] = FW'(9);
        e.elems[2] = FW'(11);
        e.sum = FW'(27);
        sb_q.push_back(e);
        send_elem(FW'(7), 8'hC3, 1'b0);
        send_elem(FW'(9), 8'hC3, 1'b0);
        send_elem(FW'(11), 8'hC3, 1'b1);
        drain();
        check("partial_issue_count", FW'(issues - i0), FW'(1));
        n_pre = 0;
`else
        send_elem(FW'(7), 8'hC3, 1'b0);
        send_elem(FW'(9), 8'hC3, 1'b0);
        send_elem(FW'(11), 8'hC3, 1'b1);
        repeat (10) @(negedge clk);
        check("partial_ignored_no_issue", FW'(issues - i0), FW'(0));
        check("partial_ignored_not_idle", FW'(idle), FW'(0));
        check("partial_ignored_in_ready", FW'(in_ready), FW'(1));
        n_pre = 3;
`endif

        // Reset after 5 of 8 elements discards the partial vector.
        for (int i = n_pre; i < 5; i++) send_elem(FW'(100 + i), 8'h99, 1'b0);
        i0 = issues;
        @(negedge clk);
        rstb = 1'b0;
        armed = 1'b1;
        #1;
        check("midrst_idle", FW'(idle), FW'(1));
        check("midrst_in_ready", FW'(in_ready), FW'(1));
        check("midrst_tree_en", FW'(tree_en), FW'(0));
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (5) @(negedge clk);
        check("midrst_no_issue", FW'(issues - i0), FW'(0));
        send_vec(8'h77, FW'(40), FW'(348));
        drain();
        check("midrst_fresh_issue", FW'(issues - i0), FW'(1));

        // Holdoff: ready stays high without a re-arm pulse.
        tb_nopulse = 1'b1;
        i0 = issues;
        send_vec(8'h21, FW'(1), FW'(36));
        send_vec(8'h22, FW'(9), FW'(100));
        repeat (20) @(negedge clk);
        check("holdoff_one_issue", FW'(issues - i0), FW'(1));
        check("holdoff_tree_ready", FW'(tree_in_ready), FW'(1));
        check("holdoff_not_idle", FW'(idle), FW'(0));
        tb_nopulse = 1'b0;
        tb_force = 1'b1;
        drain();
        check("holdoff_second_issue", FW'(issues - i0), FW'(2));

        repeat (3) @(negedge clk);
        check("end_sb_empty", FW'(sb_q.size()), FW'(0));
        check("end_idle", FW'(idle), FW'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prover_adder_tree_feeder.md
Name: prover_adder_tree_feeder

Overview:
- Transmit side of the pipelined adder tree's input interface.
- Accepts field elements serially, one per cycle, with a per-vector tag, and packs them into an ngates-wide vector.
- Issues each packed vector to the tree as a single-cycle enable, and only when the tree's input level is ready.
- Double-buffered, so one vector fills while the previous one waits for, or is handed to, the tree.

Parameters:
- ngates, 8, vector width; must equal the downstream tree's ngates; ngates >= 2.
- ntagb, 8, tag width; must equal the tree's ntagb.

Ports:
- clk  in  1  clock
- rstb  in  1  async active-low reset
- in_valid  in  1  in_data is valid this cycle
- in_data  in  `F_NBITS  field element
- in_tag  in  ntagb  vector tag; sampled with the first element of each vector
- in_last  in  1  final element of a short vector (used only with the optional feature)
- in_ready  out  1  an element is accepted on a cycle with in_valid && in_ready
- tree_in_ready  in  1  tree level-0 ready level
- tree_in_ready_pulse  in  1  tree level-0 ready rising pulse
- tree_en  out  1  single-cycle issue strobe to the tree's en
- tree_in  out  `F_NBITS x [ngates-1:0] (unpacked)  vector to the tree's in
- tree_tag  out  ntagb  tag to the tree's in_tag
- idle  out  1  both banks EMPTY and no holdoff pending

Behaviour:
- Reset (rstb low, async):
  - all bank data registers are 0; both banks EMPTY.
  - fill_sel=0, issue_sel=0, elem_idx=0, holdoff=0.
  - Outputs: tree_en=0, tree_tag=0, tree_in all zero, in_ready=1, idle=1.
  - Reset mid-operation discards partial and full vectors without issuing them.
- Bank states: EMPTY -> FILLING (first element accepted) -> FULL (element ngates-1 accepted) -> EMPTY (cycle after its tree_en).
- Filling:
  - in_ready = (bank[fill_sel] != FULL).
  - On accept, data is written to bank[fill_sel][elem_idx] and elem_idx increments.
  - When elem_idx==0, in_tag is also latched into the bank.
  - On accepting element ngates-1: elem_idx wraps to 0, the bank goes FULL, fill_sel toggles.
  - in_valid while in_ready=0 is ignored; no data is lost upstream because the element is not accepted.
- Issue rule: tree_en is a registered output, asserted for exactly one cycle when all of the following hold:
  - bank[issue_sel]==FULL
  - tree_in_ready==1
  - holdoff==0
  - tree_en was not high in the previous cycle
- Holdoff:
  - Set on tree_en; cleared on tree_in_ready_pulse.
  - This guarantees the tree has consumed the last vector and re-armed before the next issue.
- Issue timing:
  - tree_in and tree_tag are taken from bank[issue_sel] and are stable from FULL through the tree_en cycle.
  - The cycle after tree_en: bank[issue_sel] goes EMPTY and issue_sel toggles.
- Latency: last element accepted at edge t -> tree_en high in cycle t+1 at earliest (tree ready, no holdoff).
- Ordering: strict FIFO; vectors are issued in fill order with their own tags.
- Simultaneous events:
  - Filling one bank while issuing or freeing the other is permitted in the same cycle.
  - A bank freed at edge t may begin refilling at edge t+1.
- Both banks FULL: in_ready=0 until the older bank is freed.
- tree_in_ready_pulse with holdoff=0 has no effect.

Optional Feature:
- Macro: ADDER_FEEDER_PARTIAL_EN.
- Defined:
  - An accepted element with in_last=1 completes the vector early.
  - Remaining slots elem_idx+1..ngates-1 are written 0 (the additive identity), so the tree's sum is unaffected.
  - The bank goes FULL the same edge; elem_idx resets to 0.
  - in_last on element ngates-1 behaves as a normal completion.
- Undefined: in_last is ignored; every vector requires exactly ngates elements.

Decomposition:
- `F_NBITS comes from field_arith_defs.v.
- Shared package prover_feeder_pkg holds:
  - the bank state enum (EMPTY/FILLING/FULL, 2 bits);
  - a function for the index width $clog2(ngates).
- One sub-module: prover_feeder_bank, one buffer with its state, tag register, write port (idx, data, we, zero-fill) and free strobe; instantiated twice.
- Top level holds fill_sel, issue_sel, elem_idx, holdoff, and tree_en generation.

Test Plan (ngates=8, ntagb=8):
- Single vector: feed 1..8 with tag 0x5A, tree ready -> one tree_en one cycle after element 8; tree_in={1..8}, tree_tag=0x5A; the tree's out is 36.
- Back-to-back: stream 24 elements (1..24), tags 0x01/0x02/0x03 -> three tree_en in order.
  - Sums 36, 100, 164.
  - Each tree_en only after the preceding tree_in_ready_pulse.
  - in_ready drops while both banks are FULL.
- Backpressure: hold tree_in_ready=0 while 16 elements arrive -> in_ready=0 after element 16; the 17th element is not accepted until the first issue frees a bank; no element is lost or reordered.
- Partial (ADDER_FEEDER_PARTIAL_EN): elements 7,9,11 with in_last on 11, tag 0xC3 -> tree_in={7,9,11,0,0,0,0,0}, tree out 27.
  - Without the macro the vector stays FILLING.
- Reset mid-fill: assert rstb low after 5 of 8 elements -> idle=1, in_ready=1, no tree_en; the next 8 elements form a fresh vector whose tag is the one presented with the first post-reset element.
- Ready/holdoff: tree_in_ready stuck high with no pulse after an issue -> no second tree_en until tree_in_ready_pulse.
